// File: rtl/axis_tag_arb_mux.sv
// Frame-level N:1 AXI-Stream round-robin merger; stamps m_axis_tid with the source port index.
// Define AXIS_TAG_ARB_MUX_FRAME_COUNT_EN to add the frame_count output.
module axis_tag_arb_mux #(
   parameter int S_COUNT     = 4,
   parameter int DATA_WIDTH  = 8,
   parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
   parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
   parameter int TAG_WIDTH   = $clog2(S_COUNT),
   parameter int DEST_WIDTH  = 8,
   parameter bit USER_ENABLE = 1,
   parameter int USER_WIDTH  = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [S_COUNT*DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [S_COUNT*KEEP_WIDTH-1:0]   s_axis_tkeep,
   input  logic [S_COUNT-1:0]              s_axis_tvalid,
   output logic [S_COUNT-1:0]              s_axis_tready,
   input  logic [S_COUNT-1:0]              s_axis_tlast,
   input  logic [S_COUNT*DEST_WIDTH-1:0]   s_axis_tdest,
   input  logic [S_COUNT*USER_WIDTH-1:0]   s_axis_tuser,
   output logic [DATA_WIDTH-1:0]           m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]           m_axis_tkeep,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic                            m_axis_tlast,
   output logic [TAG_WIDTH-1:0]            m_axis_tid,
   output logic [DEST_WIDTH-1:0]           m_axis_tdest,
   output logic [USER_WIDTH-1:0]           m_axis_tuser
`ifdef AXIS_TAG_ARB_MUX_FRAME_COUNT_EN
   ,
   output logic [31:0]                     frame_count
`endif
);

   typedef enum logic {IDLE, ACTIVE} state_e;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [KEEP_WIDTH-1:0] keep;
      logic                  last;
      logic [TAG_WIDTH-1:0]  tid;
      logic [DEST_WIDTH-1:0] dest;
      logic [USER_WIDTH-1:0] user;
   } beat_t;

   state_e               state_q, state_d;
   logic [TAG_WIDTH-1:0] grant_q, grant_d;
   logic [TAG_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
   beat_t                head_q, head_d;
   beat_t                skid_q, skid_d;
   logic                 head_vld_q, head_vld_d;
   logic                 skid_vld_q, skid_vld_d;

   beat_t                in_beat [S_COUNT];
   logic [TAG_WIDTH-1:0] winner;
   logic [TAG_WIDTH-1:0] cand;
   logic                 found;
   logic                 in_ready;
   logic                 push;
   logic                 pop;
   logic                 unused_inputs;

   // Each port's beat arrives pre-tagged with its own index, so the mux output is final.
   for (genvar i = 0; i < S_COUNT; i++) begin : g_in
      assign in_beat[i] = '{
         data: s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH],
         keep: KEEP_ENABLE ? s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH] : {KEEP_WIDTH{1'b1}},
         last: s_axis_tlast[i],
         tid:  TAG_WIDTH'(i),
         dest: s_axis_tdest[i*DEST_WIDTH +: DEST_WIDTH],
         user: USER_ENABLE ? s_axis_tuser[i*USER_WIDTH +: USER_WIDTH] : {USER_WIDTH{1'b0}}
      };
   end

   // Disabled sideband fields leave these inputs otherwise unread.
   assign unused_inputs = ^{s_axis_tkeep, s_axis_tuser};

   // The skid entry is only ever occupied when the head is, so it alone marks "full".
   assign in_ready = (state_q == ACTIVE) && !skid_vld_q && !rst;
   assign push     = in_ready && s_axis_tvalid[grant_q];
   assign pop      = head_vld_q && m_axis_tready;

   always_comb begin
      s_axis_tready          = '0;
      s_axis_tready[grant_q] = in_ready;
   end

   // Round-robin search starting at rr_ptr and wrapping modulo S_COUNT.
   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path infers a latch.
      winner = '0;
      cand   = '0;
      found  = 1'b0;
      for (int k = 0; k < S_COUNT; k++) begin
         cand = TAG_WIDTH'((int'(rr_ptr_q) + k) % S_COUNT);
         if (!found && s_axis_tvalid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               grant_d = winner;
               state_d = ACTIVE;
            end
         end
         ACTIVE: begin
            if (push && in_beat[grant_q].last) begin
               state_d  = IDLE;
               rr_ptr_d = (grant_q == TAG_WIDTH'(S_COUNT - 1)) ? '0 : grant_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Two-entry output buffer: head drives m_axis_*, skid absorbs one beat of backpressure.
   always_comb begin
      head_d     = head_q;
      skid_d     = skid_q;
      head_vld_d = head_vld_q;
      skid_vld_d = skid_vld_q;
      if (skid_vld_q) begin
         if (pop) begin
            head_d     = skid_q;
            skid_vld_d = 1'b0;
         end
      end else if (head_vld_q) begin
         if (push && pop) begin
            head_d = in_beat[grant_q];
         end else if (push) begin
            skid_d     = in_beat[grant_q];
            skid_vld_d = 1'b1;
         end else if (pop) begin
            head_vld_d = 1'b0;
         end
      end else if (push) begin
         head_d     = in_beat[grant_q];
         head_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         head_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
         // NOTE: payload registers are cleared too, so m_axis_* read 0 after reset, not stale data.
         head_q     <= '0;
         skid_q     <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         head_vld_q <= head_vld_d;
         skid_vld_q <= skid_vld_d;
         head_q     <= head_d;
         skid_q     <= skid_d;
      end
   end

   assign m_axis_tvalid = head_vld_q;
   assign m_axis_tdata  = head_q.data;
   assign m_axis_tkeep  = KEEP_ENABLE ? head_q.keep : {KEEP_WIDTH{1'b1}};
   assign m_axis_tlast  = head_q.last;
   assign m_axis_tid    = head_q.tid;
   assign m_axis_tdest  = head_q.dest;
   assign m_axis_tuser  = USER_ENABLE ? head_q.user : {USER_WIDTH{1'b0}};

`ifdef AXIS_TAG_ARB_MUX_FRAME_COUNT_EN
   logic [31:0] frame_count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_count_q <= '0;
      end else if (pop && head_q.last) begin
         frame_count_q <= frame_count_q + 32'd1;
      end
   end

   assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_axis_tag_arb_mux.sv
// Self-checking bench for axis_tag_arb_mux: directed latency/arbitration steps plus
// randomized frames scored against a frame-level round-robin model.
module tb_axis_tag_arb_mux;

   localparam int S = 4;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic [7:0] dest;
      logic       user;
   } src_beat_t;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic [1:0] tid;
      logic [7:0] dest;
      logic       user;
   } out_beat_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] s_tdata;
   logic [3:0]  s_tkeep;
   logic [3:0]  s_tvalid;
   logic [3:0]  s_tready;
   logic [3:0]  s_tlast;
   logic [31:0] s_tdest;
   logic [3:0]  s_tuser;
   logic [7:0]  m_tdata;
   logic [0:0]  m_tkeep;
   logic        m_tvalid;
   logic        m_tready;
   logic        m_tlast;
   logic [1:0]  m_tid;
   logic [7:0]  m_tdest;
   logic [0:0]  m_tuser;
`ifdef AXIS_TAG_ARB_MUX_FRAME_COUNT_EN
   logic [31:0] frame_count;
`endif

   int checks = 0;
   int errors = 0;

   src_beat_t src_q [S][$];
   out_beat_t exp_q [$];
   int        gap [S];
   bit        ready_pat [$];
   int        model_rr = 0;

   axis_tag_arb_mux dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (s_tdata),
      .s_axis_tkeep  (s_tkeep),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .s_axis_tlast  (s_tlast),
      .s_axis_tdest  (s_tdest),
      .s_axis_tuser  (s_tuser),
`ifdef AXIS_TAG_ARB_MUX_FRAME_COUNT_EN
      .frame_count   (frame_count),
`endif
      .m_axis_tdata  (m_tdata),
      .m_axis_tkeep  (m_tkeep),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_tlast  (m_tlast),
      .m_axis_tid    (m_tid),
      .m_axis_tdest  (m_tdest),
      .m_axis_tuser  (m_tuser)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      s_tdata  = '0;
      s_tkeep  = '1;
      s_tvalid = '0;
      s_tlast  = '0;
      s_tdest  = '0;
      s_tuser  = '0;
      m_tready = 1'b1;
   endtask

   task automatic drive(input int p, input logic [7:0] d, input logic l);
      s_tvalid[p]        = 1'b1;
      s_tdata[p*8 +: 8]  = d;
      s_tlast[p]         = l;
      s_tdest[p*8 +: 8]  = 8'(8'h40 + p);
      s_tuser[p]         = l;
   endtask

   task automatic idle_port(input int p);
      s_tvalid[p] = 1'b0;
      s_tlast[p]  = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      model_rr = 0;
      for (int i = 0; i < S; i++) begin
         gap[i] = 0;
         src_q[i].delete();
      end
      exp_q.delete();
   endtask

   // A valid output beat driven by drive(): dest is 0x40+port, user mirrors tlast.
   task automatic check_out(input string tag, input logic [7:0] d, input logic l, input logic [1:0] t);
      check({tag, "_valid"}, m_tvalid, 1'b1);
      check({tag, "_beat"}, {m_tkeep, m_tdata, m_tlast, m_tid, m_tdest, m_tuser},
            {1'b1, d, l, t, 8'(8'h40 + t), l});
   endtask

   task automatic add_frame(input int p, input int len);
      src_beat_t b;
      for (int k = 0; k < len; k++) begin
         b.data = 8'($urandom);
         b.last = (k == len - 1);
         b.dest = 8'($urandom);
         b.user = 1'($urandom);
         src_q[p].push_back(b);
      end
   endtask

   // Frame-level model: every port with frames left is requesting at each arbitration,
   // so the output is whole frames chosen round-robin from the pointer.
   function automatic void model_build();
      int        cur [S];
      int        p;
      int        i;
      bit        done;
      src_beat_t b;
      out_beat_t o;
      for (int k = 0; k < S; k++) cur[k] = 0;
      p = 0;
      while (p >= 0) begin
         p = -1;
         for (int k = 0; k < S; k++) begin
            i = (model_rr + k) % S;
            if (p < 0 && cur[i] < src_q[i].size()) p = i;
         end
         if (p >= 0) begin
            done = 1'b0;
            while (!done) begin
               b = src_q[p][cur[p]];
               cur[p]++;
               o.data = b.data;
               o.last = b.last;
               o.tid  = 2'(p);
               o.dest = b.dest;
               o.user = b.user;
               exp_q.push_back(o);
               done = b.last;
            end
            model_rr = (p + 1) % S;
         end
      end
   endfunction

   // Sources hold tvalid between frames and only pause after a non-last beat, which keeps
   // every pending port requesting whenever the arbiter looks.
   task automatic run_engine(input string tag, input int budget, input int gap_pct, input int stall_pct);
      int n;
      bit hs [S];
      n = 0;
      model_build();
      while (exp_q.size() > 0 && n < budget) begin
         for (int i = 0; i < S; i++) begin
            if (gap[i] == 0 && src_q[i].size() > 0) begin
               s_tvalid[i]       = 1'b1;
               s_tdata[i*8 +: 8] = src_q[i][0].data;
               s_tlast[i]        = src_q[i][0].last;
               s_tdest[i*8 +: 8] = src_q[i][0].dest;
               s_tuser[i]        = src_q[i][0].user;
            end else begin
               s_tvalid[i] = 1'b0;
               s_tlast[i]  = 1'b0;
            end
         end
         if (ready_pat.size() > 0) m_tready = ready_pat.pop_front();
         else m_tready = ($urandom_range(99) >= stall_pct);
         mid();
         for (int i = 0; i < S; i++) hs[i] = s_tvalid[i] && s_tready[i];
         if (m_tvalid) begin
            check({tag, "_beat"}, {m_tkeep, m_tdata, m_tlast, m_tid, m_tdest, m_tuser},
                  {1'b1, exp_q[0]});
            if (m_tready) void'(exp_q.pop_front());
         end
         cyc();
         for (int i = 0; i < S; i++) begin
            if (gap[i] > 0) gap[i]--;
            if (hs[i]) begin
               if (!src_q[i][0].last && $urandom_range(99) < gap_pct)
                  gap[i] = $urandom_range(3, 1);
               void'(src_q[i].pop_front());
            end
         end
         n++;
      end
      check({tag, "_drained"}, exp_q.size(), 0);
      clear_inputs();
      for (int k = 0; k < 3; k++) begin
         mid();
         check({tag, "_no_extra"}, m_tvalid, 1'b0);
         cyc();
      end
      exp_q.delete();
   endtask

   initial begin
      logic [8:0] pat;

      clear_inputs();
      rst = 1'b1;
      cyc();
      do_reset();

      // Reset state
      mid();
      check("rst_tready", s_tready, 4'b0000);
      check("rst_mvalid", m_tvalid, 1'b0);
      check("rst_mpayload", {m_tdata, m_tlast, m_tid, m_tdest, m_tuser}, 0);

      // Single 3-beat frame on port 2
      cyc(); drive(2, 8'h11, 1'b0);
      mid(); check("t1_c0_rdy", s_tready, 4'b0000);
             check("t1_c0_mvalid", m_tvalid, 1'b0);
      cyc();
      mid(); check("t1_c1_rdy", s_tready, 4'b0100);
             check("t1_c1_mvalid", m_tvalid, 1'b0);
      cyc(); drive(2, 8'h22, 1'b0);
      mid(); check_out("t1_c2", 8'h11, 1'b0, 2'd2);
      cyc(); drive(2, 8'h33, 1'b1);
      mid(); check_out("t1_c3", 8'h22, 1'b0, 2'd2);
      cyc(); idle_port(2);
      mid(); check_out("t1_c4", 8'h33, 1'b1, 2'd2);
             check("t1_c4_rdy", s_tready, 4'b0000);
      cyc();
      mid(); check("t1_c5_mvalid", m_tvalid, 1'b0);
      cyc();

      // Ports 0,1,3 then all four, round-robin order
      do_reset();
      add_frame(0, 2); add_frame(1, 2); add_frame(3, 2);
      run_engine("rr_round1", 200, 0, 0);
      for (int i = 0; i < S; i++) add_frame(i, 2);
      run_engine("rr_round2", 200, 0, 0);

      // Port 1 4-beat frame under a stall pattern
      add_frame(1, 4);
      pat = 9'b111001011;
      for (int k = 8; k >= 0; k--) ready_pat.push_back(pat[k]);
      run_engine("stall", 200, 0, 0);

      // Port 3 arrives mid-frame of port 0
      do_reset();
      drive(0, 8'hA0, 1'b0);
      mid(); check("t4_c0_rdy", s_tready, 4'b0000);
      cyc(); drive(3, 8'hD0, 1'b1);
      mid(); check("t4_c1_rdy", s_tready, 4'b0001);
      cyc(); drive(0, 8'hA1, 1'b0);
      mid(); check("t4_c2_rdy", s_tready, 4'b0001);
             check_out("t4_c2", 8'hA0, 1'b0, 2'd0);
      cyc(); drive(0, 8'hA2, 1'b1);
      mid(); check("t4_c3_rdy", s_tready, 4'b0001);
             check_out("t4_c3", 8'hA1, 1'b0, 2'd0);
      cyc(); idle_port(0);
      mid(); check("t4_m1_rdy", s_tready, 4'b0000);
             check_out("t4_c4", 8'hA2, 1'b1, 2'd0);
      cyc();
      mid(); check("t4_m2_rdy", s_tready, 4'b1000);
             check("t4_c5_mvalid", m_tvalid, 1'b0);
      cyc(); idle_port(3);
      mid(); check_out("t4_c6", 8'hD0, 1'b1, 2'd3);
             check("t4_c6_rdy", s_tready, 4'b0000);
      cyc();
      mid(); check("t4_c7_mvalid", m_tvalid, 1'b0);
      cyc();

      // Reset in the middle of a port 2 frame
      drive(2, 8'hB0, 1'b0);
      cyc();
      mid(); check("t5_c1_rdy", s_tready, 4'b0100);
      cyc(); drive(2, 8'hB1, 1'b0);
      mid(); check_out("t5_c2", 8'hB0, 1'b0, 2'd2);
      cyc(); rst = 1'b1; drive(2, 8'hB2, 1'b0);
      cyc(); rst = 1'b0; drive(2, 8'hC0, 1'b0);
      mid(); check("t5_post_rdy", s_tready, 4'b0000);
             check("t5_post_mvalid", m_tvalid, 1'b0);
             check("t5_post_payload", {m_tdata, m_tlast, m_tid, m_tdest, m_tuser}, 0);
      cyc();
      mid(); check("t5_regrant_rdy", s_tready, 4'b0100);
             check("t5_regrant_mvalid", m_tvalid, 1'b0);
      cyc(); drive(2, 8'hC1, 1'b1);
      mid(); check_out("t5_new0", 8'hC0, 1'b0, 2'd2);
      cyc(); idle_port(2);
      mid(); check_out("t5_new1", 8'hC1, 1'b1, 2'd2);
      cyc();
      mid(); check("t5_end_mvalid", m_tvalid, 1'b0);
      cyc();

      // Randomized frames, source pauses and output backpressure
      do_reset();
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < S; i++) begin
            for (int f = 0; f < int'($urandom_range(2)); f++) add_frame(i, $urandom_range(5, 1));
         end
         run_engine("rand", 3000, 30, 30);
      end

`ifdef AXIS_TAG_ARB_MUX_FRAME_COUNT_EN
      do_reset();
      mid(); check("fc_reset", frame_count, 32'd0);
      cyc();
      add_frame(0, 2); add_frame(2, 1); add_frame(3, 3); add_frame(1, 1); add_frame(2, 2);
      run_engine("fc", 500, 20, 20);
      mid(); check("fc_five", frame_count, 32'd5);
      cyc();
      do_reset();
      mid(); check("fc_cleared", frame_count, 32'd0);
      cyc();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/axis_tag_arb_mux.md
Name: axis_tag_arb_mux

Overview:
- Frame-level N:1 AXI-Stream merger with round-robin arbitration. It stamps each output frame's tid with the index of the source port it came from.
- It is the return-path counterpart of axis_switch: switch outputs feed into it, and the tid it produces can later be copied into tdest to route replies back through axis_switch.
- Whole frames are never interleaved. Output is registered through a 2-entry skid buffer, so throughput is one beat per cycle.

Parameters:
- S_COUNT, 4, number of input ports (2..16).
- DATA_WIDTH, 8, tdata width.
- KEEP_ENABLE, (DATA_WIDTH>8), carry tkeep when 1; when 0, m_axis_tkeep is all-ones.
- KEEP_WIDTH, (DATA_WIDTH/8), tkeep width.
- TAG_WIDTH, $clog2(S_COUNT), width of m_axis_tid.
- DEST_WIDTH, 8, tdest width, passed through unchanged.
- USER_ENABLE, 1, carry tuser when 1; when 0, m_axis_tuser is 0.
- USER_WIDTH, 1, tuser width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axis_tdata  in  S_COUNT*DATA_WIDTH  input data, port i at slice i
- s_axis_tkeep  in  S_COUNT*KEEP_WIDTH  input keep
- s_axis_tvalid  in  S_COUNT  input valid
- s_axis_tready  out  S_COUNT  input ready
- s_axis_tlast  in  S_COUNT  input end of frame
- s_axis_tdest  in  S_COUNT*DEST_WIDTH  input dest
- s_axis_tuser  in  S_COUNT*USER_WIDTH  input user
- m_axis_tdata  out  DATA_WIDTH  output data
- m_axis_tkeep  out  KEEP_WIDTH  output keep
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  output end of frame
- m_axis_tid  out  TAG_WIDTH  source port index of the frame
- m_axis_tdest  out  DEST_WIDTH  dest of the granted source
- m_axis_tuser  out  USER_WIDTH  user of the granted source

Behaviour:
- Reset values:
  - state=IDLE, grant=0, rr_ptr=0.
  - s_axis_tready=0, m_axis_tvalid=0, skid buffer empty.
  - All other m_axis_* outputs are 0.
  - Reset asserted mid-frame aborts the frame: state returns to IDLE and buffered beats are discarded. No truncated tlast is emitted.
- State IDLE:
  - s_axis_tready is all zeros.
  - If any s_axis_tvalid bit is set, the grant register loads the winner and the state moves to ACTIVE at the next edge.
  - Winner: the lowest index i >= rr_ptr with tvalid set; if none, wrap around and take the lowest index i < rr_ptr with tvalid set.
  - If no tvalid bit is set, stay in IDLE.
- State ACTIVE:
  - s_axis_tready[grant] = skid buffer not full. All other s_axis_tready bits are 0.
  - Each accepted beat is written to the output register with tid = grant.
  - When a beat with tlast=1 is accepted: rr_ptr <= (grant+1) mod S_COUNT and the state moves to IDLE.
- Latency:
  - A source tvalid rising while IDLE in cycle N gives s_axis_tready in cycle N+1.
  - The first m_axis_tvalid appears in cycle N+2.
  - After a tlast handshake in cycle M, the next frame's tready is no earlier than cycle M+2 (one dead cycle for arbitration).
- Skid buffer:
  - Depth 2, registered outputs.
  - A full skid buffer deasserts input ready the same cycle.
  - With m_axis_tready=1 continuously, throughput is one beat per cycle with no bubbles inside a frame.
  - m_axis_* outputs must stay stable while m_axis_tvalid=1 and m_axis_tready=0.
- Boundary rules:
  - A non-granted source with tvalid held high waits; it is never dropped and cannot starve (round-robin).
  - A granted source that deasserts tvalid mid-frame keeps the grant indefinitely.
  - A single-beat frame (tvalid and tlast together) is legal.
  - When S_COUNT is not a power of two, the rr_ptr wrap uses modulo S_COUNT.

Optional Feature:
- Macro: AXIS_TAG_ARB_MUX_FRAME_COUNT_EN.
- When defined, add output port frame_count [31:0]:
  - Increments by 1 on each output handshake with m_axis_tlast=1.
  - Wraps 0xFFFFFFFF -> 0.
  - Reset value is 0.
- When undefined, the port and its counter do not exist and the behaviour is otherwise identical.

Test Plan:
- Single 3-beat frame on port 2 (data 0x11,0x22,0x33), m_axis_tready=1. Tvalid is asserted in cycle 0, so s_axis_tready[2] is high in cycle 1. Output shows 3 consecutive beats in cycles 2-4 with tid=2 and tlast on 0x33.
- Ports 0, 1 and 3 each hold a 2-beat frame ready simultaneously after reset. Output frame order is tid 0, 1, 3. A second round with all ports ready then continues in order 0, 1, 2, 3.
- Port 1 sends a 4-beat frame while m_axis_tready toggles 1,0,0,1,0,1,1. No beat is lost or duplicated, output data is unchanged while stalled, and tlast appears exactly once.
- Port 0 sends a frame while port 3 asserts tvalid mid-frame. Port 3 sees no tready until cycle M+2 after port 0's tlast handshake, and no interleaving occurs.
- Reset is asserted for 1 cycle in the middle of a port 2 frame. All readies and m_axis_tvalid are 0 the next cycle. A subsequent frame on port 2 is granted (rr_ptr=0 search) and output with tid=2.
- With AXIS_TAG_ARB_MUX_FRAME_COUNT_EN defined, 5 frames across mixed ports give frame_count=5. Reset returns it to 0.
